// File: rtl/tc_pkg.sv
// Shared types and FP16 constants for the tensor-core GEMM array and its drain stage.
package tc_pkg;

    localparam int KACC_WIDTH = 91;
    localparam int KACC_FRAC  = 48;

    localparam int EXP_BIAS  = 15;
    localparam int MANT_BITS = 10;

    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;

    typedef logic [KACC_WIDTH-1:0] kacc_t;
    typedef logic [15:0]           fp16_t;
    typedef kacc_t [0:3][0:3]      kacc_tile_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_t;

endpackage

// File: rtl/kulisch_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module kulisch_lzc #(
    parameter int WIDTH = 91,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    lz_count
);

    // Scan upwards so the highest set bit wins.
    always_comb begin
        lz_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                lz_count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/kulisch_fp16_drain.sv
// Drains a 4x4 Kulisch accumulator tile as 16 RNE-rounded FP16 beats, row-major.
// Build option KULISCH_DRAIN_SAT_EN: overflow saturates to +/-65504 and raises sat_flag.
module kulisch_fp16_drain
    import tc_pkg::*;
#(
    parameter int AWIDTH    = KACC_WIDTH,
    parameter int FRAC_BITS = KACC_FRAC,
    parameter int DWIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [0:3][0:3][AWIDTH-1:0]   in_tile,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DWIDTH-1:0]             out_data,
    output logic [1:0]                    out_row,
    output logic [1:0]                    out_col,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef KULISCH_DRAIN_SAT_EN
    ,
    output logic                          sat_flag
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and out_* stay frozen while valid & !ready.

    localparam int LZ_W      = $clog2(AWIDTH + 1);
    localparam int NORM_MIN  = FRAC_BITS - EXP_BIAS + 1;   // bit position of 2^-14
    localparam int SUB_SHIFT = AWIDTH - 1 - NORM_MIN;
    localparam int EXP_TOP   = AWIDTH - NORM_MIN;

`ifdef KULISCH_DRAIN_SAT_EN
    localparam logic [15:0] OVF_CODE = FP16_MAXF;
`else
    localparam logic [15:0] OVF_CODE = FP16_INF;
`endif

    drain_state_t                state, state_nx;
    logic [3:0]                  idx;
    logic [0:3][0:3][AWIDTH-1:0] tile_q;
    logic                        en;
    logic                        accept;
    logic                        last_hs;
    logic                        issue;

    assign en      = !out_valid || out_ready;
    assign accept  = in_valid && in_ready;
    assign last_hs = out_valid && out_ready && out_last;
    assign issue   = (state == ST_RUN) && en;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (en && idx == 4'd15) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_hs) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= 4'd0;
            tile_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                tile_q <= in_tile;
                idx    <= 4'd0;
            end else if (issue) begin
                idx <= idx + 4'd1;
            end
        end
    end

    // Stage 1: sign, magnitude and leading-zero count of the issued element.
    logic [AWIDTH-1:0] cur;
    logic              cur_sign;
    logic [AWIDTH-1:0] cur_mag;
    logic [LZ_W-1:0]   cur_lzc;

    assign cur      = tile_q[idx[3:2]][idx[1:0]];
    assign cur_sign = cur[AWIDTH-1];
    assign cur_mag  = cur_sign ? -cur : cur;

    kulisch_lzc #(
        .WIDTH (AWIDTH),
        .CW    (LZ_W)
    ) u_lzc (
        .value    (cur_mag),
        .lz_count (cur_lzc)
    );

    logic              s1_valid;
    logic              s1_sign;
    logic [AWIDTH-1:0] s1_mag;
    logic [LZ_W-1:0]   s1_lzc;
    logic [3:0]        s1_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_lzc   <= '0;
            s1_idx   <= 4'd0;
        end else if (en) begin
            s1_valid <= issue;
            if (issue) begin
                s1_sign <= cur_sign;
                s1_mag  <= cur_mag;
                s1_lzc  <= cur_lzc;
                s1_idx  <= idx;
            end
        end
    end

    // Stage 2: subnormals share the normal datapath by shifting as if the exponent
    // field were 1 with no hidden bit, so a mantissa carry lands in the exponent.
    logic                      normal;
    logic [LZ_W-1:0]           shift;
    logic [AWIDTH-2:0]         norm;
    logic [7:0]                exp_pre;
    logic [MANT_BITS-1:0]      mant;
    logic                      guard;
    logic                      sticky;
    logic                      round_up;
    logic [8+MANT_BITS-1:0]    rounded;
    logic                      ovf;
    logic [14:0]               mag15;
    logic [15:0]               fp;

    always_comb begin
        normal   = (s1_lzc <= LZ_W'(SUB_SHIFT));
        shift    = normal ? s1_lzc : LZ_W'(SUB_SHIFT);
        norm     = (AWIDTH-1)'(s1_mag << shift);
        exp_pre  = normal ? (8'(EXP_TOP) - 8'(s1_lzc)) : 8'd0;
        mant     = norm[AWIDTH-2 -: MANT_BITS];
        guard    = norm[AWIDTH-2-MANT_BITS];
        sticky   = |norm[AWIDTH-3-MANT_BITS:0];
        round_up = guard && (sticky || mant[0]);
        rounded  = {exp_pre, mant} + {{(8+MANT_BITS-1){1'b0}}, round_up};
        ovf      = (rounded[8+MANT_BITS-1:MANT_BITS] >= 8'd31);
        mag15    = ovf ? OVF_CODE[14:0] : rounded[14:0];
        fp       = {s1_sign && (|mag15), mag15};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= 2'd0;
            out_col   <= 2'd0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= fp;
                out_row  <= s1_idx[3:2];
                out_col  <= s1_idx[1:0];
                out_last <= (s1_idx == 4'd15);
            end else begin
                out_last <= 1'b0;
            end
        end
    end

`ifdef KULISCH_DRAIN_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (accept) begin
            sat_flag <= 1'b0;
        end else if (en && s1_valid && ovf) begin
            sat_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_kulisch_fp16_drain.sv
// Directed bench for kulisch_fp16_drain: conversion vectors, backpressure, back-to-back, async reset.
module tb_kulisch_fp16_drain;

    localparam int AW = 91;

    logic                      clk;
    logic                      rst_n;
    logic [0:3][0:3][AW-1:0]   in_tile;
    logic                      in_valid;
    logic                      in_ready;
    logic [15:0]               out_data;
    logic [1:0]                out_row;
    logic [1:0]                out_col;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
`ifdef KULISCH_DRAIN_SAT_EN
    logic                      sat_flag;
`endif

    int checks   = 0;
    int failures = 0;

    logic [0:3][0:3][AW-1:0] t1, t2;
    logic [15:0] exp1 [16];
    logic [15:0] exp2 [16];
    logic [15:0] exp_cur [16];

    kulisch_fp16_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_tile   (in_tile),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef KULISCH_DRAIN_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one tile at a falling edge once in_ready is seen; accepted on the next rising edge.
    task automatic send_tile(input logic [0:3][0:3][AW-1:0] t);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("send_in_ready", 32'(in_ready), 32'd1);
        in_tile  = t;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Consume beats against exp_cur; first iteration is the falling edge right after acceptance.
    task automatic drain(input bit rnd, input int stop_after, input bit timing);
        int n_hs = 0;
        int cyc = 0;
        int first = -1;
        bit stalled = 1'b0;
        logic [15:0] pd;
        logic [1:0] pr, pc;
        logic pl;
        while (n_hs < stop_after && cyc < 400) begin
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(pd));
                check("hold_row", 32'(out_row), 32'(pr));
                check("hold_col", 32'(out_col), 32'(pc));
                check("hold_last", 32'(out_last), 32'(pl));
            end
            check("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (first < 0) first = cyc;
                check("data", 32'(out_data), 32'(exp_cur[n_hs]));
                check("row", 32'(out_row), 32'(n_hs / 4));
                check("col", 32'(out_col), 32'(n_hs % 4));
                check("last", 32'(out_last), (n_hs == 15) ? 32'd1 : 32'd0);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = out_valid && !out_ready;
            pd = out_data;
            pr = out_row;
            pc = out_col;
            pl = out_last;
            if (out_valid && out_ready) n_hs++;
            cyc++;
        end
        check("handshakes", 32'(n_hs), 32'(stop_after));
        if (timing) begin
            check("first_latency", 32'(first), 32'd2);
            check("burst_cycles", 32'(cyc), 32'(stop_after + 2));
        end
    endtask

    task automatic post_drain();
        @(negedge clk);
        check("in_ready_after_last", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        t1 = '0;
        t1[0][0] = 91'(1) << 48;
        t1[0][1] = -(91'(1) << 49);
        for (int i = 0; i < 16; i++) exp1[i] = 16'h0000;
        exp1[0] = 16'h3C00;
        exp1[1] = 16'hC000;

        t2[0][0] = (91'(1) << 48) + (91'(1) << 37);       exp2[0]  = 16'h3C00;
        t2[0][1] = (91'(1) << 48) + (91'(1) << 37) + 91'(1); exp2[1] = 16'h3C01;
        t2[0][2] = (91'(1) << 48) + (91'(3) << 37);       exp2[2]  = 16'h3C02;
        t2[0][3] = 91'(1) << 24;                          exp2[3]  = 16'h0001;
        t2[1][0] = 91'(65504) << 48;                      exp2[4]  = 16'h7BFF;
        t2[1][1] = 91'(65520) << 48;
        t2[1][2] = -(91'(1) << 90);
`ifdef KULISCH_DRAIN_SAT_EN
        exp2[5] = 16'h7BFF;
        exp2[6] = 16'hFBFF;
`else
        exp2[5] = 16'h7C00;
        exp2[6] = 16'hFC00;
`endif
        t2[1][3] = 91'(1);                                exp2[7]  = 16'h0000;
        t2[2][0] = -(91'(1));                             exp2[8]  = 16'h0000;
        t2[2][1] = (91'(1) << 34) - (91'(1) << 23);       exp2[9]  = 16'h0400;
        t2[2][2] = -(91'(3) << 47);                       exp2[10] = 16'hBE00;
        t2[2][3] = 91'(1) << 63;                          exp2[11] = 16'h7800;
        t2[3][0] = 91'(1) << 47;                          exp2[12] = 16'h3800;
        t2[3][1] = 91'(3) << 24;                          exp2[13] = 16'h0003;
        t2[3][2] = -(91'(1) << 24);                       exp2[14] = 16'h8001;
        t2[3][3] = 91'(1000) << 48;                       exp2[15] = 16'h63D0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_tile   = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_row", 32'(out_row), 32'd0);
        check("rst_out_col", 32'(out_col), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
`ifdef KULISCH_DRAIN_SAT_EN
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
`endif
        #3 rst_n = 1'b1;

        // Simple tile at full throughput.
        exp_cur = exp1;
        send_tile(t1);
        drain(1'b0, 16, 1'b1);
        post_drain();

        // Rounding and range vectors under random backpressure.
        exp_cur = exp2;
        send_tile(t2);
        drain(1'b1, 16, 1'b0);
        post_drain();
`ifdef KULISCH_DRAIN_SAT_EN
        check("sat_flag_set", 32'(sat_flag), 32'd1);
`endif

        // Back-to-back: in_valid stays high with the second tile queued.
        @(negedge clk);
        out_ready = 1'b1;
        in_tile   = t1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_tile = t2;
`ifdef KULISCH_DRAIN_SAT_EN
        check("sat_flag_cleared", 32'(sat_flag), 32'd0);
`endif
        exp_cur = exp1;
        drain(1'b0, 16, 1'b1);
        @(negedge clk);
        check("b2b_in_ready_rise", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_cur = exp2;
        drain(1'b0, 16, 1'b1);
        post_drain();

        // Asynchronous reset in the middle of a tile.
        exp_cur = exp2;
        send_tile(t2);
        drain(1'b0, 5, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_row", 32'(out_row), 32'd0);
        check("midrst_out_col", 32'(out_col), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_quiet", 32'(out_valid), 32'd0);
        end
        exp_cur = exp1;
        send_tile(t1);
        drain(1'b0, 16, 1'b1);
        post_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
